// File: rtl/pdes_sched_ctrl.sv
// Scheduler controller for a parallel discrete-event simulator: seeds LPs, moves
// core events into an external priority queue, dispatches to idle cores, tracks GVT.
module pdes_sched_ctrl #(
  parameter int NUM_CORE  = 4,
  parameter int NB_COREID = 2,
  parameter int NUM_LP    = 8,
  parameter int NB_LPID   = 3,
  parameter int TIME_WID  = 16,
  parameter int MSG_WID   = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic [TIME_WID-1:0]          i_end_time,
  input  logic                         i_pause,
  input  logic [NUM_CORE-1:0]          i_core_evt_vld,
  input  logic [NUM_CORE*MSG_WID-1:0]  i_core_evt_data,
  output logic [NUM_CORE-1:0]          o_core_evt_ack,
  input  logic [NUM_CORE-1:0]          i_core_ready,
  output logic [NUM_CORE-1:0]          o_core_disp_vld,
  output logic [MSG_WID-1:0]           o_disp_data,
  output logic                         o_q_enq,
  output logic [MSG_WID-1:0]           o_q_enq_data,
  output logic                         o_q_deq,
  input  logic [MSG_WID-1:0]           i_q_head,
  input  logic                         i_q_empty,
  input  logic                         i_q_full,
  input  logic [TIME_WID-1:0]          i_core_min_time,
  input  logic                         i_core_min_vld,
  output logic [TIME_WID-1:0]          o_gvt,
  output logic                         o_done,
  output logic                         o_busy,
  output logic [31:0]                  o_disp_count
);

  localparam int ANTI_BIT = TIME_WID + NB_LPID;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t                r_state, w_state_next;
  logic [TIME_WID-1:0]   r_end_time;
  logic [TIME_WID-1:0]   r_gvt;
  logic [31:0]           r_disp_count;
  logic [NB_LPID-1:0]    r_lp_cnt;
  logic [NB_COREID-1:0]  r_rx_ptr;
  logic [NB_COREID-1:0]  r_dp_ptr;

  logic [MSG_WID-1:0]    w_core_msg [NUM_CORE];
  logic [MSG_WID-1:0]    w_rx_msg;
  logic [NB_COREID-1:0]  w_rx_idx, w_dp_idx;
  logic                  w_rx_grant, w_dp_grant, w_rx_null, w_lp_adv;
  logic                  w_cand_vld;
  logic [TIME_WID-1:0]   w_cand, w_head_time;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORE; gi++) begin : g_msg
      assign w_core_msg[gi] = i_core_evt_data[gi*MSG_WID +: MSG_WID];
    end
  endgenerate

  // First requester at or after ptr, wrapping around the core set.
  function automatic logic [NB_COREID-1:0] rr_pick(input logic [NUM_CORE-1:0] req,
                                                   input logic [NB_COREID-1:0] ptr);
    logic [NB_COREID-1:0] pick;
    logic                 found;
    int                   idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CORE; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CORE) idx = idx - NUM_CORE;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = NB_COREID'(idx);
      end
    end
    return pick;
  endfunction

  function automatic logic [NB_COREID-1:0] ptr_after(input logic [NB_COREID-1:0] g);
    return (g == NB_COREID'(NUM_CORE - 1)) ? '0 : g + 1'b1;
  endfunction

  assign w_rx_idx  = rr_pick(i_core_evt_vld, r_rx_ptr);
  assign w_dp_idx  = rr_pick(i_core_ready, r_dp_ptr);
  assign w_rx_msg  = w_core_msg[w_rx_idx];
  assign w_rx_null = w_rx_msg[ANTI_BIT] && (w_rx_msg[ANTI_BIT-1:0] == '0);

  assign w_rx_grant = ((r_state == S_RUN) || (r_state == S_PAUSE)) &&
                      !i_q_full && (|i_core_evt_vld);
  // Receive wins the cycle; pause gates dispatch immediately, even before PAUSE is entered.
  assign w_dp_grant = (r_state == S_RUN) && !i_pause && !w_rx_grant &&
                      !i_q_empty && (|i_core_ready);

  assign w_head_time = i_q_head[TIME_WID-1:0];

  always_comb begin
    w_cand_vld = i_core_min_vld || !i_q_empty;
    w_cand     = w_head_time;
    if (i_core_min_vld && !i_q_empty)
      w_cand = (i_core_min_time < w_head_time) ? i_core_min_time : w_head_time;
    else if (i_core_min_vld)
      w_cand = i_core_min_time;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    w_lp_adv        = 1'b0;
    o_q_enq         = 1'b0;
    o_q_enq_data    = w_rx_msg;
    o_q_deq         = w_dp_grant;
    o_core_evt_ack  = w_rx_grant ? (NUM_CORE'(1) << w_rx_idx) : '0;
    o_core_disp_vld = w_dp_grant ? (NUM_CORE'(1) << w_dp_idx) : '0;
    o_disp_data     = i_q_head;
    unique case (r_state)
      S_IDLE: if (i_start) w_state_next = S_INIT;
      S_INIT: begin
        o_q_enq_data = '0;
        o_q_enq_data[TIME_WID +: NB_LPID] = r_lp_cnt;
        if (!i_q_full) begin
          o_q_enq  = 1'b1;
          w_lp_adv = 1'b1;
          if (r_lp_cnt == NB_LPID'(NUM_LP - 1)) w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        o_q_enq = w_rx_grant && !w_rx_null;
        if (r_gvt > r_end_time) w_state_next = S_DONE;
        else if (i_pause)       w_state_next = S_PAUSE;
      end
      S_PAUSE: begin
        o_q_enq = w_rx_grant && !w_rx_null;
        if (r_gvt > r_end_time) w_state_next = S_DONE;
        else if (!i_pause)      w_state_next = S_RUN;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_end_time   <= '0;
      r_gvt        <= '0;
      r_disp_count <= '0;
      r_lp_cnt     <= '0;
      r_rx_ptr     <= '0;
      r_dp_ptr     <= '0;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_end_time   <= i_end_time;
        r_gvt        <= '0;
        r_disp_count <= '0;
        r_lp_cnt     <= '0;
      end
      if (w_lp_adv) r_lp_cnt <= r_lp_cnt + 1'b1;
      // GVT only moves forward, and only from a live candidate.
      if ((r_state == S_RUN || r_state == S_PAUSE) && w_cand_vld && (w_cand >= r_gvt))
        r_gvt <= w_cand;
      if (w_rx_grant) r_rx_ptr <= ptr_after(w_rx_idx);
      if (w_dp_grant) begin
        r_dp_ptr <= ptr_after(w_dp_idx);
        if (r_disp_count != '1) r_disp_count <= r_disp_count + 1'b1;
      end
    end
  end

  assign o_gvt        = r_gvt;
  assign o_disp_count = r_disp_count;
  assign o_done       = (r_state == S_DONE);
  assign o_busy       = (r_state == S_INIT) || (r_state == S_RUN) || (r_state == S_PAUSE);

endmodule
